histogram_readout: RTL and testbench
====================================

Name: histogram_readout

Overview:
- Consumer of the scratch-memory histogram built by the histogram control/datapath.
- After histogram_computation_done, it reads each bin in order, keeps a running sum, and writes the cumulative histogram (CDF) to a CDF memory for the equalization stage.
- Also reports the total pixel count and a sticky saturation flag.
- Same memory-interface style as the histogram writer: set address, wait a fixed read latency, capture data.

Parameters:
NUM_BINS, 256, number of histogram bins (power of two)
BIN_AW, 8, bin address width (log2 NUM_BINS)
CNT_W, 16, scratch-memory bin counter width
CDF_W, 20, cumulative-sum and CDF data width (CDF_W >= CNT_W)
RD_LAT, 2, scratch read latency in cycles from scratch_re to valid scratch_rdata (>=1)

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
start_readout  in  1  one-cycle start pulse, sampled only in IDLE
scratch_re  out  1  scratch read enable
scratch_raddr  out  BIN_AW  scratch read address
scratch_rdata  in  CNT_W  scratch read data, valid RD_LAT cycles after scratch_re
scratch_we  out  1  scratch write enable (bin clear; see Optional Feature)
scratch_waddr  out  BIN_AW  scratch write address
scratch_wdata  out  CNT_W  scratch write data (always 0)
cdf_we  out  1  CDF memory write enable
cdf_addr  out  BIN_AW  CDF write address
cdf_wdata  out  CDF_W  CDF write data
busy  out  1  high in every state except IDLE
readout_done  out  1  one-cycle pulse at completion
total_count  out  CDF_W  final sum, registered at DONE, held until next DONE
overflow  out  1  sticky saturation flag, cleared on accepted start

Behaviour:
- Reset (sync, highest priority, also mid-operation):
  - state to IDLE; bin_idx, acc and wait counter to 0.
  - All outputs 0, including total_count and overflow.
  - No memory write is issued on or after the reset edge.
- Memory strobes (scratch_re, scratch_we, cdf_we) and their addresses/data are decoded from registered state and counters. They are stable for the whole cycle.
- States:
  - IDLE: if start_readout, clear acc, bin_idx and overflow, go to SET_RD. Otherwise stay.
  - SET_RD: scratch_re=1, scratch_raddr=bin_idx. Go to WAIT if RD_LAT>1, else CAPTURE.
  - WAIT: hold for RD_LAT-1 cycles (counter), then CAPTURE.
  - CAPTURE: sum = acc + zero-extended scratch_rdata.
    - If the sum carries out of CDF_W: acc = all-ones, overflow=1.
    - Else acc = sum.
    - Go to WRITE.
  - WRITE: cdf_we=1, cdf_addr=bin_idx, cdf_wdata=acc (post-capture value). Bin clear per Optional Feature. Go to NEXT.
  - NEXT: if bin_idx==NUM_BINS-1 go to DONE, else bin_idx+1 and go to SET_RD.
  - DONE: readout_done=1, total_count=acc, go to IDLE.
- Timing with defaults:
  - start sampled at cycle 0; SET_RD for bin k at cycle 1+5k.
  - CDF write for bin k at cycle 4+5k.
  - readout_done high in cycle 1281.
  - General form: 1 + NUM_BINS*(RD_LAT+3) cycles from start to done.
- start_readout while busy: ignored, no effect on the sequence.
- start and reset in the same cycle: reset wins.
- Saturated acc stays all-ones for the rest of the frame. Subsequent CDF entries are all-ones.
- bin_idx never wraps mid-frame. NEXT at NUM_BINS-1 always exits.

Optional Feature:
- Macro: HISTOGRAM_READOUT_CLEAR_BINS_EN.
- Defined: in WRITE, also scratch_we=1, scratch_waddr=bin_idx, scratch_wdata=0, in the same cycle as cdf_we. After DONE the scratch memory is all zero, ready for the next frame.
- Undefined: scratch_we is tied 0; scratch_waddr and scratch_wdata are tied 0. Ports remain present. Scratch contents are unchanged.

Test Plan:
- All 256 bins = 0, start at cycle 0 -> 256 cdf writes, all cdf_wdata=0; total_count=0; overflow=0; readout_done exactly in cycle 1281.
- Every bin = 1 -> cdf[k]=k+1; cdf[255]=256; total_count=256; busy high in cycles 1..1281.
- Only bin 100 = 4096 -> cdf[0..99]=0, cdf[100..255]=4096; total_count=4096.
- Bins 0..31 = 65535 -> cdf[15]=1048560; cdf[16..255]=1048575; overflow=1 from bin 16 onward; total_count=1048575. A new start clears overflow.
- Reset asserted at cycle 600 of a run -> busy=0 and no cdf_we/scratch_we from cycle 601. Extra start pulses during a later run are ignored. A restart gives the full correct CDF.
- With HISTOGRAM_READOUT_CLEAR_BINS_EN defined, bins = k%7 -> correct CDF, scratch_we coincident with each cdf_we, and a scratch readback shows all 0. Without the macro, scratch_we never asserts.

Source files
------------

// File: rtl/histogram_readout_if.sv
// Control and memory bus of the histogram readout block.
// master: readout engine; slave: scratch/CDF memories and the controller.
interface histogram_readout_if #(
  parameter int BIN_AW = 8,
  parameter int CNT_W  = 16,
  parameter int CDF_W  = 20
);
  logic              start_readout;
  logic              scratch_re;
  logic [BIN_AW-1:0] scratch_raddr;
  logic [CNT_W-1:0]  scratch_rdata;
  logic              scratch_we;
  logic [BIN_AW-1:0] scratch_waddr;
  logic [CNT_W-1:0]  scratch_wdata;
  logic              cdf_we;
  logic [BIN_AW-1:0] cdf_addr;
  logic [CDF_W-1:0]  cdf_wdata;
  logic              busy;
  logic              readout_done;
  logic [CDF_W-1:0]  total_count;
  logic              overflow;

  modport master (
    input  start_readout, scratch_rdata,
    output scratch_re, scratch_raddr,
    output scratch_we, scratch_waddr, scratch_wdata,
    output cdf_we, cdf_addr, cdf_wdata,
    output busy, readout_done, total_count, overflow
  );

  modport slave (
    output start_readout, scratch_rdata,
    input  scratch_re, scratch_raddr,
    input  scratch_we, scratch_waddr, scratch_wdata,
    input  cdf_we, cdf_addr, cdf_wdata,
    input  busy, readout_done, total_count, overflow
  );
endinterface

// File: rtl/histogram_readout.sv
// Histogram readout: walks the scratch histogram and writes its CDF.
// Ports: clock, reset (sync, active-high); bus = histogram_readout_if.master
//   (start, scratch read/clear port, CDF write port, busy/done/total/overflow).
// Option: HISTOGRAM_READOUT_CLEAR_BINS_EN zeroes each scratch bin after use.
module histogram_readout #(
  parameter int NUM_BINS = 256,
  parameter int BIN_AW   = 8,
  parameter int CNT_W    = 16,
  parameter int CDF_W    = 20,
  parameter int RD_LAT   = 2
) (
  input  logic clock,
  input  logic reset,
  histogram_readout_if.master bus
);

  // Wait counter only needs to reach RD_LAT-2.
  localparam int WCW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST =
    WCW'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [BIN_AW-1:0] LAST_BIN = BIN_AW'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_RD,
    S_WAIT,
    S_CAPTURE,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [BIN_AW-1:0] r_bin_idx;
  logic [CDF_W-1:0]  r_acc;
  logic [WCW-1:0]    r_wait_cnt;
  logic              r_overflow;
  logic [CDF_W-1:0]  r_total;

  state_t            w_state_nxt;
  logic [BIN_AW-1:0] w_bin_nxt;
  logic [CDF_W-1:0]  w_acc_nxt;
  logic [WCW-1:0]    w_wait_nxt;
  logic              w_ovf_nxt;
  logic [CDF_W-1:0]  w_total_nxt;
  logic [CDF_W:0]    w_sum;

  // Extra top bit catches the carry out of the accumulator.
  assign w_sum = {1'b0, r_acc} + (CDF_W + 1)'(bus.scratch_rdata);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bin_idx  <= '0;
      r_acc      <= '0;
      r_wait_cnt <= '0;
      r_overflow <= 1'b0;
      r_total    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bin_idx  <= w_bin_nxt;
      r_acc      <= w_acc_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_overflow <= w_ovf_nxt;
      r_total    <= w_total_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin_idx;
    w_acc_nxt   = r_acc;
    w_wait_nxt  = r_wait_cnt;
    w_ovf_nxt   = r_overflow;
    w_total_nxt = r_total;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start_readout) begin
          w_acc_nxt   = '0;
          w_bin_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_wait_nxt  = '0;
          w_state_nxt = S_SET_RD;
        end
      end
      S_SET_RD: begin
        w_wait_nxt  = '0;
        w_state_nxt = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        if (w_sum[CDF_W]) begin
          w_acc_nxt = '1;
          w_ovf_nxt = 1'b1;
        end else begin
          w_acc_nxt = w_sum[CDF_W-1:0];
        end
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (r_bin_idx == LAST_BIN) begin
          // Latch here so total_count is valid alongside readout_done.
          w_total_nxt = r_acc;
          w_state_nxt = S_DONE;
        end else begin
          w_bin_nxt   = r_bin_idx + 1'b1;
          w_state_nxt = S_SET_RD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.scratch_re    = (r_state == S_SET_RD);
  assign bus.scratch_raddr = r_bin_idx;
  assign bus.cdf_we        = (r_state == S_WRITE);
  assign bus.cdf_addr      = r_bin_idx;
  assign bus.cdf_wdata     = r_acc;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.readout_done  = (r_state == S_DONE);
  assign bus.total_count   = r_total;
  assign bus.overflow      = r_overflow;

`ifdef HISTOGRAM_READOUT_CLEAR_BINS_EN
  assign bus.scratch_we    = (r_state == S_WRITE);
  assign bus.scratch_waddr = r_bin_idx;
  assign bus.scratch_wdata = '0;
`else
  assign bus.scratch_we    = 1'b0;
  assign bus.scratch_waddr = '0;
  assign bus.scratch_wdata = '0;
`endif

endmodule

// File: tb/tb_histogram_readout.sv
// Directed bench for histogram_readout with scratch and CDF memory models.
// Scratch model returns data RD_LAT=2 cycles after scratch_re.
module tb_histogram_readout;
  localparam int NB = 256;
  localparam int AW = 8;
  localparam int CW = 16;
  localparam int DW = 20;
  localparam int RL = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  histogram_readout_if #(.BIN_AW(AW), .CNT_W(CW), .CDF_W(DW)) bus();

  histogram_readout #(
    .NUM_BINS(NB), .BIN_AW(AW), .CNT_W(CW), .CDF_W(DW), .RD_LAT(RL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  logic [CW-1:0] scratch [NB];
  logic [DW-1:0] cdf_mem [NB];
  logic [CW-1:0] rd_s1;
  logic fill_req = 1'b0;
  int fill_mode = 0;
  int cyc = 0;
  int t0 = 0;
  int cdf_wr_cnt = 0;
  int sw_cnt = 0;
  int tim_err = 0;
  int coinc_err = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int done_rel, busy_bad, ovf_at1, post_busy, post_done;
  int wr0, tim0, sw0, co0;

  function automatic logic [CW-1:0] pat(int mode, int k);
    case (mode)
      1: return 16'd1;
      2: return (k == 100) ? 16'd4096 : 16'd0;
      3: return (k < 32) ? 16'hFFFF : 16'd0;
      4: return CW'(k % 7);
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_cdf(int mode, int k);
    longint s = 0;
    for (int j = 0; j <= k; j++) begin
      s += longint'(pat(mode, j));
      if (s > 1048575) s = 1048575;
    end
    return DW'(s);
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (fill_req) begin
      for (int k = 0; k < NB; k++) scratch[k] <= pat(fill_mode, k);
    end else if (bus.scratch_we) begin
      scratch[bus.scratch_waddr] <= bus.scratch_wdata;
    end
    if (bus.scratch_re) rd_s1 <= scratch[bus.scratch_raddr];
    bus.scratch_rdata <= rd_s1;
    if (bus.cdf_we) cdf_mem[bus.cdf_addr] <= bus.cdf_wdata;
  end

  always @(negedge clock) begin
    if (bus.cdf_we) begin
      cdf_wr_cnt++;
      if (cyc - t0 != 4 + 5 * int'(bus.cdf_addr)) tim_err++;
    end
    if (bus.scratch_we) sw_cnt++;
    if (bus.scratch_we !== bus.cdf_we) coinc_err++;
    if (bus.scratch_we && bus.scratch_waddr !== bus.cdf_addr) coinc_err++;
  end

  // Loads a pattern, pulses start, follows the frame until done or
  // until one cycle after an injected reset.
  task automatic run_frame(input int mode, input bit extra,
                           input int rst_at);
    fill_mode = mode;
    fill_req = 1'b1;
    @(negedge clock);
    fill_req = 1'b0;
    wr0 = cdf_wr_cnt;
    tim0 = tim_err;
    sw0 = sw_cnt;
    co0 = coinc_err;
    t0 = cyc;
    done_rel = -1;
    busy_bad = 0;
    ovf_at1 = -1;
    for (int r = 0; r < 2000; r++) begin
      if (r == rst_at + 1) begin
        reset = 1'b0;
        bus.start_readout = 1'b0;
        break;
      end
      bus.start_readout = (r == 0) ||
        (extra && (r == 300 || r == 1000 || r == 1281));
      reset = (r == rst_at);
      if (r >= 1 && bus.busy !== 1'b1) busy_bad++;
      if (r == 1) ovf_at1 = int'(bus.overflow);
      if (bus.readout_done === 1'b1) begin
        done_rel = r;
        break;
      end
      @(negedge clock);
    end
    if (rst_at > 2000) begin
      @(negedge clock);
      post_busy = int'(bus.busy);
      post_done = int'(bus.readout_done);
      bus.start_readout = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start_readout = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({bus.busy, bus.readout_done, bus.overflow, bus.cdf_we,
         bus.scratch_re, bus.scratch_we} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 000000",
        {bus.busy, bus.readout_done, bus.overflow, bus.cdf_we,
         bus.scratch_re, bus.scratch_we});
    end
    n_cmp++;
    if (bus.total_count !== 20'd0 || bus.cdf_wdata !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_data: got total %0d cdf %0d want 0 0",
        bus.total_count, bus.cdf_wdata);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_all_zero();
    int errs;
    run_frame(0, 1'b0, 100000);
    n_cmp++;
    if (done_rel !== 1281) begin
      n_bad++;
      $display("FAIL zero_done_cycle: got %0d want 1281", done_rel);
    end
    n_cmp++;
    if (cdf_wr_cnt - wr0 !== 256) begin
      n_bad++;
      $display("FAIL zero_wr_count: got %0d want 256", cdf_wr_cnt - wr0);
    end
    n_cmp++;
    if (tim_err - tim0 !== 0) begin
      n_bad++;
      $display("FAIL zero_wr_timing: got %0d late writes want 0",
        tim_err - tim0);
    end
    errs = 0;
    for (int k = 0; k < NB; k++) if (cdf_mem[k] !== 20'd0) errs++;
    n_cmp++;
    if (errs !== 0) begin
      n_bad++;
      $display("FAIL zero_cdf: got %0d bad bins want 0", errs);
    end
    n_cmp++;
    if (bus.total_count !== 20'd0 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_total: got %0d/%b want 0/0",
        bus.total_count, bus.overflow);
    end
    n_cmp++;
    if (post_busy !== 0 || post_done !== 0) begin
      n_bad++;
      $display("FAIL zero_after_done: got busy %0d done %0d want 0 0",
        post_busy, post_done);
    end
  endtask

  task automatic test_all_ones();
    int errs;
    run_frame(1, 1'b0, 100000);
    errs = 0;
    for (int k = 0; k < NB; k++) if (cdf_mem[k] !== DW'(k + 1)) errs++;
    n_cmp++;
    if (errs !== 0) begin
      n_bad++;
      $display("FAIL ones_cdf: got %0d bad bins want 0", errs);
    end
    n_cmp++;
    if (cdf_mem[255] !== 20'd256) begin
      n_bad++;
      $display("FAIL ones_cdf255: got %0d want 256", cdf_mem[255]);
    end
    n_cmp++;
    if (bus.total_count !== 20'd256) begin
      n_bad++;
      $display("FAIL ones_total: got %0d want 256", bus.total_count);
    end
    n_cmp++;
    if (busy_bad !== 0 || done_rel !== 1281) begin
      n_bad++;
      $display("FAIL ones_busy: got %0d idle cycles done %0d want 0 1281",
        busy_bad, done_rel);
    end
  endtask

  task automatic test_single_bin();
    run_frame(2, 1'b0, 100000);
    n_cmp++;
    if (cdf_mem[99] !== 20'd0 || cdf_mem[100] !== 20'd4096) begin
      n_bad++;
      $display("FAIL single_edge: got %0d,%0d want 0,4096",
        cdf_mem[99], cdf_mem[100]);
    end
    n_cmp++;
    if (cdf_mem[255] !== 20'd4096 || bus.total_count !== 20'd4096) begin
      n_bad++;
      $display("FAIL single_total: got %0d,%0d want 4096,4096",
        cdf_mem[255], bus.total_count);
    end
  endtask

  task automatic test_saturate();
    int errs;
    run_frame(3, 1'b0, 100000);
    n_cmp++;
    if (cdf_mem[15] !== 20'd1048560) begin
      n_bad++;
      $display("FAIL sat_cdf15: got %0d want 1048560", cdf_mem[15]);
    end
    n_cmp++;
    if (cdf_mem[16] !== 20'd1048575 || cdf_mem[255] !== 20'd1048575) begin
      n_bad++;
      $display("FAIL sat_cdf16: got %0d,%0d want 1048575,1048575",
        cdf_mem[16], cdf_mem[255]);
    end
    errs = 0;
    for (int k = 0; k < NB; k++) if (cdf_mem[k] !== exp_cdf(3, k)) errs++;
    n_cmp++;
    if (errs !== 0) begin
      n_bad++;
      $display("FAIL sat_cdf: got %0d bad bins want 0", errs);
    end
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.total_count !== 20'd1048575) begin
      n_bad++;
      $display("FAIL sat_flags: got %b/%0d want 1/1048575",
        bus.overflow, bus.total_count);
    end
  endtask

  task automatic test_clear_bins();
    int errs;
    int zs;
    run_frame(4, 1'b0, 100000);
    n_cmp++;
    if (ovf_at1 !== 0 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL mod7_ovf_clear: got %0d/%b want 0/0",
        ovf_at1, bus.overflow);
    end
    n_cmp++;
    if (cdf_mem[6] !== 20'd21 || bus.total_count !== 20'd762) begin
      n_bad++;
      $display("FAIL mod7_vals: got %0d,%0d want 21,762",
        cdf_mem[6], bus.total_count);
    end
    errs = 0;
    for (int k = 0; k < NB; k++) if (cdf_mem[k] !== exp_cdf(4, k)) errs++;
    n_cmp++;
    if (errs !== 0) begin
      n_bad++;
      $display("FAIL mod7_cdf: got %0d bad bins want 0", errs);
    end
    zs = 0;
`ifdef HISTOGRAM_READOUT_CLEAR_BINS_EN
    for (int k = 0; k < NB; k++) if (scratch[k] !== 16'd0) zs++;
    n_cmp++;
    if (zs !== 0 || sw_cnt - sw0 !== 256 || coinc_err - co0 !== 0) begin
      n_bad++;
      $display("FAIL clear_bins: got %0d nonzero %0d we %0d skew want 0 256 0",
        zs, sw_cnt - sw0, coinc_err - co0);
    end
`else
    for (int k = 0; k < NB; k++) if (scratch[k] !== pat(4, k)) zs++;
    n_cmp++;
    if (zs !== 0 || sw_cnt - sw0 !== 0) begin
      n_bad++;
      $display("FAIL no_clear: got %0d changed %0d we want 0 0",
        zs, sw_cnt - sw0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int errs;
    int act;
    run_frame(1, 1'b0, 600);
    n_cmp++;
    if ({bus.busy, bus.cdf_we, bus.scratch_we, bus.readout_done} !== 4'b0)
    begin
      n_bad++;
      $display("FAIL rst_mid_601: got %b want 0000",
        {bus.busy, bus.cdf_we, bus.scratch_we, bus.readout_done});
    end
    n_cmp++;
    if (bus.total_count !== 20'd0 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_regs: got %0d/%b want 0/0",
        bus.total_count, bus.overflow);
    end
    act = 0;
    repeat (100) begin
      if (bus.busy || bus.cdf_we || bus.scratch_we) act++;
      @(negedge clock);
    end
    n_cmp++;
    if (act !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_quiet: got %0d active cycles want 0", act);
    end
    run_frame(3, 1'b1, 100000);
    n_cmp++;
    if (done_rel !== 1281 || cdf_wr_cnt - wr0 !== 256 ||
        tim_err - tim0 !== 0) begin
      n_bad++;
      $display("FAIL restart_seq: got done %0d wr %0d late %0d want 1281 256 0",
        done_rel, cdf_wr_cnt - wr0, tim_err - tim0);
    end
    errs = 0;
    for (int k = 0; k < NB; k++) if (cdf_mem[k] !== exp_cdf(3, k)) errs++;
    n_cmp++;
    if (errs !== 0 || bus.total_count !== 20'd1048575) begin
      n_bad++;
      $display("FAIL restart_cdf: got %0d bad total %0d want 0 1048575",
        errs, bus.total_count);
    end
    n_cmp++;
    if (post_busy !== 0) begin
      n_bad++;
      $display("FAIL start_in_done: got busy %0d want 0", post_busy);
    end
  endtask

  task automatic test_start_reset_same();
    bus.start_readout = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    bus.start_readout = 1'b0;
    reset = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.scratch_re !== 1'b0) begin
      n_bad++;
      $display("FAIL start_and_reset: got busy %b re %b want 0 0",
        bus.busy, bus.scratch_re);
    end
    @(negedge clock);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_and_reset_idle: got busy %b want 0", bus.busy);
    end
  endtask

  initial begin
    bus.start_readout = 1'b0;
    test_reset();
    test_all_zero();
    test_all_ones();
    test_single_bin();
    test_saturate();
    test_clear_bins();
    test_reset_mid();
    test_start_reset_same();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
